// File: rtl/aes_sbox_pkg.sv
// Shared constants, mode encoding and GF(2^8) / affine helpers for the AES S-box bank.
package aes_sbox_pkg;

  localparam int unsigned SBOX_W = 8;
  localparam logic [SBOX_W-1:0] AFF_C = 8'h63;

  localparam logic SBOX_FWD = 1'b0;
  localparam logic SBOX_INV = 1'b1;

  typedef logic [SBOX_W-1:0] sbox_byte_t;

  // Forward affine: M*b ^ 0x63, M expressed as the sum of four left rotations plus identity.
  function automatic sbox_byte_t aff_fwd(input sbox_byte_t b);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ AFF_C;
  endfunction

  // Inverse affine: M^-1*(b ^ 0x63), M^-1 being rotations by 1, 3 and 6.
  function automatic sbox_byte_t aff_inv(input sbox_byte_t b);
    sbox_byte_t x;
    x = b ^ AFF_C;
    return {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]};
  endfunction

  // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1.
  function automatic sbox_byte_t gf_mul(input sbox_byte_t a, input sbox_byte_t b);
    sbox_byte_t p;
    sbox_byte_t aa;
    p  = '0;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[3'(i)]) p = p ^ aa;
      aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1B) : {aa[6:0], 1'b0};
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 = x^2 * x^4 * ... * x^128; maps 0 to 0 naturally.
  function automatic sbox_byte_t gf_inv(input sbox_byte_t x);
    sbox_byte_t sq;
    sbox_byte_t acc;
    sq  = gf_mul(x, x);
    acc = sq;
    for (int i = 0; i < 6; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

endpackage

// File: rtl/aes_sbox_lane.sv
// Single-byte combinational S-box lane split at the inversion boundary.
module aes_sbox_lane
  import aes_sbox_pkg::*;
(
  input  logic              mode,
  input  logic [SBOX_W-1:0] front_in,
  output logic [SBOX_W-1:0] front_out_c,
  input  logic              back_mode,
  input  logic [SBOX_W-1:0] back_in,
  output logic [SBOX_W-1:0] back_out_c
);

  logic [SBOX_W-1:0] pre;

  // Front half: inverse mode un-does the affine before inversion
  always_comb begin
    pre         = (mode == SBOX_INV) ? aff_inv(front_in) : front_in;
    front_out_c = gf_inv(pre);
  end

  // Back half: forward mode applies the affine after inversion
  always_comb begin
    back_out_c = (back_mode == SBOX_FWD) ? aff_fwd(back_in) : back_in;
  end

endmodule

// File: rtl/aes_sbox_pipe.sv
// Bank of AES forward/inverse S-box lanes in a 1- or 2-stage valid/ready pipeline.
module aes_sbox_pipe
  import aes_sbox_pkg::*;
#(
  parameter int unsigned LANES  = 4,
  parameter int unsigned STAGES = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_mode,
  input  logic [SBOX_W*LANES-1:0]  in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_mode,
  output logic [SBOX_W*LANES-1:0]  out_data
);

  localparam int unsigned DW = SBOX_W * LANES;

  if (STAGES != 1 && STAGES != 2) begin : g_bad_stages
    $error("aes_sbox_pipe: STAGES must be 1 or 2");
  end
  if (LANES < 1 || LANES > 16) begin : g_bad_lanes
    $error("aes_sbox_pipe: LANES must be in 1..16");
  end

  logic [DW-1:0] front_c;
  logic [DW-1:0] back_c;
  logic [DW-1:0] back_in;
  logic          back_mode;
  logic          src_valid;
  logic          load_out;

  for (genvar i = 0; i < int'(LANES); i++) begin : g_lane
    aes_sbox_lane u_lane (
      .mode        (in_mode),
      .front_in    (in_data[i*SBOX_W +: SBOX_W]),
      .front_out_c (front_c[i*SBOX_W +: SBOX_W]),
      .back_mode   (back_mode),
      .back_in     (back_in[i*SBOX_W +: SBOX_W]),
      .back_out_c  (back_c[i*SBOX_W +: SBOX_W])
    );
  end

  assign load_out = !out_valid || out_ready;

  if (STAGES == 2) begin : g_two
    logic          s1_valid;
    logic          s1_mode;
    logic [DW-1:0] s1_data;
    logic          load_s1;

    assign load_s1   = !s1_valid || load_out;
    assign in_ready  = load_s1;
    assign src_valid = s1_valid;
    assign back_in   = s1_data;
    assign back_mode = s1_mode;

    // Stage 1: holds the inversion result and its mode
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1_valid <= 1'b0;
        s1_mode  <= SBOX_FWD;
        s1_data  <= '0;
      end else if (load_s1) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_data <= front_c;
          s1_mode <= in_mode;
        end
      end
    end
  end else begin : g_one
    assign in_ready  = load_out;
    assign src_valid = in_valid;
    assign back_in   = front_c;
    assign back_mode = in_mode;
  end

  // Output stage: captures the finished substitution, holds it while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_mode  <= SBOX_FWD;
      out_data  <= '0;
    end else if (load_out) begin
      out_valid <= src_valid;
      if (src_valid) begin
        out_data <= back_c;
        out_mode <= back_mode;
      end
    end
  end

endmodule

// File: tb/tb_aes_sbox_pipe.sv
// Scoreboard bench: DUT A (LANES=4, STAGES=2) and DUT B (LANES=16, STAGES=1).
module tb_aes_sbox_pipe;

  typedef struct packed {
    logic         mode;
    logic [127:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  logic         in_valid_a, in_ready_a, in_mode_a, out_valid_a, out_ready_a, out_mode_a;
  logic [31:0]  in_data_a, out_data_a;
  logic         in_valid_b, in_ready_b, in_mode_b, out_valid_b, out_ready_b, out_mode_b;
  logic [127:0] in_data_b, out_data_b;

  exp_t exp_a[$];
  exp_t exp_b[$];

  logic [7:0] fwd_tab[256];
  logic [7:0] inv_tab[256];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int outs_a = 0;
  int outs_b = 0;
  bit rand_rdy_a = 0;
  bit rand_rdy_b = 0;

  aes_sbox_pipe #(.LANES(4), .STAGES(2)) u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid_a), .in_ready(in_ready_a), .in_mode(in_mode_a), .in_data(in_data_a),
    .out_valid(out_valid_a), .out_ready(out_ready_a), .out_mode(out_mode_a), .out_data(out_data_a)
  );

  aes_sbox_pipe #(.LANES(16), .STAGES(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid_b), .in_ready(in_ready_b), .in_mode(in_mode_b), .in_data(in_data_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .out_mode(out_mode_b), .out_data(out_data_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Random consumer backpressure when enabled
  always @(posedge clk) begin
    #1;
    if (rand_rdy_a) out_ready_a = 1'($urandom_range(0, 1));
    if (rand_rdy_b) out_ready_b = 1'($urandom_range(0, 1));
  end

  // Polynomial product over GF(2) reduced by 0x11B, plain integer arithmetic
  function automatic int pmul(input int a, input int b);
    int p;
    p = 0;
    for (int i = 0; i < 8; i++) if (((b >> i) & 1) != 0) p = p ^ (a << i);
    for (int k = 14; k >= 8; k--) if (((p >> k) & 1) != 0) p = p ^ ('h11B << (k - 8));
    return p;
  endfunction

  // S-box from the definition: brute-force inverse, then bitwise affine with constant 0x63
  task automatic build_tables();
    int inv, s, bt;
    for (int x = 0; x < 256; x++) begin
      inv = 0;
      for (int y = 1; y < 256; y++) if (pmul(x, y) == 1) inv = y;
      s = 0;
      for (int i = 0; i < 8; i++) begin
        bt = ((inv >> i) ^ (inv >> ((i + 4) % 8)) ^ (inv >> ((i + 5) % 8)) ^
              (inv >> ((i + 6) % 8)) ^ (inv >> ((i + 7) % 8)) ^ ('h63 >> i)) & 1;
        s = s | (bt << i);
      end
      fwd_tab[x] = 8'(s);
      inv_tab[s] = 8'(x);
    end
  endtask

  function automatic logic [127:0] model(input logic m, input logic [127:0] d, input int lanes);
    logic [127:0] r;
    r = '0;
    for (int j = 0; j < lanes; j++)
      r[j*8 +: 8] = m ? inv_tab[d[j*8 +: 8]] : fwd_tab[d[j*8 +: 8]];
    return r;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Present one transaction; push its expected result when it is accepted
  task automatic send(input bit b, input logic m, input logic [127:0] d, input logic [127:0] e);
    int t;
    if (b) begin in_valid_b = 1'b1; in_mode_b = m; in_data_b = d; end
    else begin in_valid_a = 1'b1; in_mode_a = m; in_data_a = d[31:0]; end
    t = 0;
    forever begin
      @(negedge clk);
      if (b ? in_ready_b : in_ready_a) begin
        if (b) exp_b.push_back('{m, e}); else exp_a.push_back('{m, e});
        break;
      end
      t++;
      if (t >= 200) begin
        checks++; errors++;
        $display("FAIL send_timeout dut=%0d: in_ready stayed 0, expected 1 within 200 cycles", b);
        break;
      end
    end
    @(posedge clk); #1;
    in_valid_a = 1'b0;
    in_valid_b = 1'b0;
  endtask

  task automatic drain(input bit b);
    int t;
    rand_rdy_a = 0; rand_rdy_b = 0;
    if (b) out_ready_b = 1'b1; else out_ready_a = 1'b1;
    t = 0;
    while ((b ? exp_b.size() : exp_a.size()) != 0 && t < 100) begin
      @(posedge clk); #1; t++;
    end
    chk(b ? "drain_b" : "drain_a", 128'(b ? exp_b.size() : exp_a.size()), 128'(0));
  endtask

  task automatic rand_phase(input bit b, input int n);
    logic m;
    logic [127:0] d;
    if (b) rand_rdy_b = 1; else rand_rdy_a = 1;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
      m = 1'($urandom);
      d = {$urandom, $urandom, $urandom, $urandom};
      if (!b) d = 128'(d[31:0]);
      send(b, m, d, model(m, d, b ? 16 : 4));
    end
    drain(b);
  endtask

  // Output monitor A: scoreboard compare plus stall stability
  always @(negedge clk) begin : mon_a
    exp_t e;
    logic held;
    logic [31:0] hd;
    logic hm;
    if (!rst_n) held = 1'b0;
    else begin
      if (held) begin
        checks++;
        if (!out_valid_a || out_data_a !== hd || out_mode_a !== hm) begin
          errors++;
          $display("FAIL stall_hold_a: got v=%b m=%b d=%h, expected v=1 m=%b d=%h",
                   out_valid_a, out_mode_a, out_data_a, hm, hd);
        end
      end
      if (out_valid_a && out_ready_a) begin
        checks++;
        if (exp_a.size() == 0) begin
          errors++;
          $display("FAIL out_a_unexpected: got result %h with empty scoreboard", out_data_a);
        end else begin
          e = exp_a.pop_front();
          outs_a++;
          if (out_data_a !== e.data[31:0] || out_mode_a !== e.mode) begin
            errors++;
            $display("FAIL out_a: got m=%b d=%h, expected m=%b d=%h",
                     out_mode_a, out_data_a, e.mode, e.data[31:0]);
          end
        end
      end
      held = out_valid_a && !out_ready_a;
      hd = out_data_a;
      hm = out_mode_a;
    end
  end

  // Output monitor B: scoreboard compare plus stall stability
  always @(negedge clk) begin : mon_b
    exp_t e;
    logic held;
    logic [127:0] hd;
    logic hm;
    if (!rst_n) held = 1'b0;
    else begin
      if (held) begin
        checks++;
        if (!out_valid_b || out_data_b !== hd || out_mode_b !== hm) begin
          errors++;
          $display("FAIL stall_hold_b: got v=%b m=%b d=%h, expected v=1 m=%b d=%h",
                   out_valid_b, out_mode_b, out_data_b, hm, hd);
        end
      end
      if (out_valid_b && out_ready_b) begin
        checks++;
        if (exp_b.size() == 0) begin
          errors++;
          $display("FAIL out_b_unexpected: got result %h with empty scoreboard", out_data_b);
        end else begin
          e = exp_b.pop_front();
          outs_b++;
          if (out_data_b !== e.data || out_mode_b !== e.mode) begin
            errors++;
            $display("FAIL out_b: got m=%b d=%h, expected m=%b d=%h",
                     out_mode_b, out_data_b, e.mode, e.data);
          end
        end
      end
      held = out_valid_b && !out_ready_b;
      hd = out_data_b;
      hm = out_mode_b;
    end
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] x, sx;
    logic [127:0] d;
    int c0, o0;
    rst_n = 1'b0;
    in_valid_a = 0; in_mode_a = 0; in_data_a = '0; out_ready_a = 0;
    in_valid_b = 0; in_mode_b = 0; in_data_b = '0; out_ready_b = 0;
    build_tables();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid_a", 128'(out_valid_a), 128'(0));
    chk("reset_out_data_a", 128'(out_data_a), 128'(0));
    chk("reset_out_mode_a", 128'(out_mode_a), 128'(0));
    chk("reset_out_valid_b", 128'(out_valid_b), 128'(0));
    chk("reset_out_data_b", out_data_b, 128'(0));
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("reset_in_ready_a", 128'(in_ready_a), 128'(1));
    chk("reset_in_ready_b", 128'(in_ready_b), 128'(1));

    // Known-answer vectors with exact latency on A
    out_ready_a = 1'b1;
    send(0, 1'b0, 128'h FF530100, 128'h 16ED7C63);
    chk("lat_a_edge_n", 128'(out_valid_a), 128'(0));
    @(posedge clk); #1;
    chk("lat_a_edge_n1", 128'(out_valid_a), 128'(1));
    send(0, 1'b1, 128'h 16ED6300, 128'h FF530052);
    drain(0);

    // Alternating forward/inverse round trips, one per cycle
    c0 = cyc; o0 = outs_a;
    for (int i = 0; i < 256; i++) begin
      for (int j = 0; j < 4; j++) x[j*8 +: 8] = 8'(i + 64 * j);
      sx = model(1'b0, 128'(x), 4);
      send(0, 1'b0, 128'(x), 128'(sx));
      send(0, 1'b1, 128'(sx), 128'(x));
    end
    chk("throughput_cycles", 128'(cyc - c0), 128'(512));
    drain(0);
    chk("throughput_outputs", 128'(outs_a - o0), 128'(512));

    // Backpressure: 5-cycle stall with a continuous input stream
    out_ready_a = 1'b0;
    fork
      begin
        repeat (5) @(posedge clk);
        #1;
        chk("bp_accepts", 128'(exp_a.size()), 128'(2));
        chk("bp_in_ready_low", 128'(in_ready_a), 128'(0));
        out_ready_a = 1'b1;
        #1;
        chk("bp_in_ready_rise", 128'(in_ready_a), 128'(1));
      end
      begin
        for (int i = 0; i < 8; i++) begin
          d = 128'($urandom);
          send(0, 1'(i), d, model(1'(i), d, 4));
        end
      end
    join
    drain(0);

    // Bubble collapse: item in output stage, empty stage 1 still accepts
    out_ready_a = 1'b0;
    d = 128'($urandom);
    send(0, 1'b0, d, model(1'b0, d, 4));
    @(posedge clk); #1;
    chk("bubble_out_valid", 128'(out_valid_a), 128'(1));
    chk("bubble_in_ready_half", 128'(in_ready_a), 128'(1));
    d = 128'($urandom);
    send(0, 1'b1, d, model(1'b1, d, 4));
    chk("bubble_in_ready_full", 128'(in_ready_a), 128'(0));
    drain(0);

    rand_phase(0, 200);

    // Reset mid-stream on A with two items in flight
    out_ready_a = 1'b0;
    for (int i = 0; i < 2; i++) begin
      d = 128'($urandom);
      send(0, 1'(i), d, model(1'(i), d, 4));
    end
    chk("rst_pre_valid_a", 128'(out_valid_a), 128'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_valid_a", 128'(out_valid_a), 128'(0));
    chk("rst_out_data_a", 128'(out_data_a), 128'(0));
    exp_a.delete();
    exp_b.delete();
    @(negedge clk) rst_n = 1'b1;
    out_ready_a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rst_no_spurious_a", 128'(out_valid_a), 128'(0));
    end
    send(0, 1'b0, 128'h 00000053, 128'h 636363ED);
    chk("rst_lat_a_n", 128'(out_valid_a), 128'(0));
    @(posedge clk); #1;
    chk("rst_lat_a_n1", 128'(out_valid_a), 128'(1));
    drain(0);

    // DUT B: single stage, 16 lanes
    out_ready_b = 1'b1;
    d = {32'h FF530100, 32'h 16ED6300, 32'h 01234567, 32'h 89ABCDEF};
    send(1, 1'b0, d, model(1'b0, d, 16));
    chk("lat_b_edge_n", 128'(out_valid_b), 128'(1));
    drain(1);
    rand_phase(1, 150);

    out_ready_b = 1'b0;
    d = {$urandom, $urandom, $urandom, $urandom};
    send(1, 1'b1, d, model(1'b1, d, 16));
    in_valid_b = 1'b1; in_mode_b = 1'b0; in_data_b = ~d;
    chk("rst_pre_valid_b", 128'(out_valid_b), 128'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_valid_b", 128'(out_valid_b), 128'(0));
    chk("rst_out_data_b", out_data_b, 128'(0));
    in_valid_b = 1'b0;
    exp_b.delete();
    @(negedge clk) rst_n = 1'b1;
    out_ready_b = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rst_no_spurious_b", 128'(out_valid_b), 128'(0));
    end
    d = {$urandom, $urandom, $urandom, $urandom};
    send(1, 1'b1, d, model(1'b1, d, 16));
    chk("rst_lat_b_n", 128'(out_valid_b), 128'(1));
    drain(1);

    chk("final_queue_a", 128'(exp_a.size()), 128'(0));
    chk("final_queue_b", 128'(exp_b.size()), 128'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
